// File: rtl/pipe_test_pkg.sv
// pipe_test_pkg
// Shared definitions for the pipe benchmark checkers and generators:
//   - mode codes for the reference pattern selector
//   - 32-bit LFSR width, tap positions and next-state helper
//   - default LFSR seed (must be nonzero)
package pipe_test_pkg;

    localparam logic [1:0] MODE_COUNT = 2'b00;
    localparam logic [1:0] MODE_LFSR  = 2'b01;
    localparam logic [1:0] MODE_WALK  = 2'b10;

    localparam int LFSR_W     = 32;
    localparam int LFSR_TAP_A = 31;
    localparam int LFSR_TAP_B = 21;
    localparam int LFSR_TAP_C = 1;
    localparam int LFSR_TAP_D = 0;

    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

    // Shift left, feedback of the four taps enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/pipe_pattern_gen.sv
// pipe_pattern_gen
// Reference pattern generator shared by the pipe-in checker and pipe-out source.
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-high; counter=0, lfsr=SEED, walk=1
//   mode     in   pattern select (00 count, 01 LFSR, 10 walking-ones, 11 = count)
//   advance  in   step the selected pattern by one word
//   expected out  current pattern word, combinational from generator state
module pipe_pattern_gen
    import pipe_test_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mode,
    input  logic              advance,
    output logic [DATA_W-1:0] expected
);

    logic [DATA_W-1:0] count_q, count_d;
    logic [LFSR_W-1:0] lfsr_q,  lfsr_d;
    logic [DATA_W-1:0] walk_q,  walk_d;
    logic [DATA_W-1:0] lfsr_rep;

    // The 32-bit LFSR word is repeated across wider buses; narrower buses
    // take its low bits.
    always_comb begin
        lfsr_rep = '0;
        for (int i = 0; i < DATA_W; i++) begin
            lfsr_rep[i] = lfsr_q[i % LFSR_W];
        end
    end

    always_comb begin
        case (mode)
            MODE_LFSR: expected = lfsr_rep;
            MODE_WALK: expected = walk_q;
            default:   expected = count_q;
        endcase
    end

    // Only the selected pattern steps; the others hold their state.
    always_comb begin
        count_d = count_q;
        lfsr_d  = lfsr_q;
        walk_d  = walk_q;
        if (advance) begin
            case (mode)
                MODE_LFSR: lfsr_d = lfsr_next(lfsr_q);
                MODE_WALK: walk_d = {walk_q[DATA_W-2:0], walk_q[DATA_W-1]};
                default:   count_d = count_q + DATA_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            lfsr_q  <= SEED;
            walk_q  <= DATA_W'(1);
        end else begin
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            walk_q  <= walk_d;
        end
    end

endmodule

// File: rtl/pipe_in_checker.sv
// pipe_in_checker
// Integrity checker behind a BTPipeIn endpoint: regenerates the host pattern,
// compares each written word, counts words and errors, and drives an advisory
// ready from a rotating throttle mask.
// Optional build macro: PIPE_IN_CHECKER_ERR_CAPTURE_EN (first-error capture).
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   mode                   pattern select (see pipe_test_pkg)
//   throttle_set/_val      load the throttle mask (1 bits = ready cycles)
//   pipe_in_write/_data    endpoint write strobe and word
//   pipe_in_ready          registered advisory ready
//   error_count            saturating mismatch count
//   word_count             wrapping count of written words
//   first_err_*            first mismatch record (zero when capture is built out)
//
// Handshake: a word is consumed on every cycle pipe_in_write is high,
// regardless of pipe_in_ready. Ready is only a pacing hint to the host;
// writes while ready is low are checked and counted like any other.
module pipe_in_checker
    import pipe_test_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                ERR_W      = 16,
    parameter int                THROTTLE_W = 32,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic                  throttle_set,
    input  logic [THROTTLE_W-1:0] throttle_val,
    input  logic                  pipe_in_write,
    input  logic [DATA_W-1:0]     pipe_in_data,
    output logic                  pipe_in_ready,
    output logic [ERR_W-1:0]      error_count,
    output logic [31:0]           word_count,
    output logic                  first_err_valid,
    output logic [31:0]           first_err_index,
    output logic [DATA_W-1:0]     first_err_expected,
    output logic [DATA_W-1:0]     first_err_received
);

    logic [DATA_W-1:0]     expected;
    logic                  mismatch;
    logic [THROTTLE_W-1:0] throttle_q, throttle_d;
    logic                  ready_q;
    logic [ERR_W-1:0]      err_q, err_d;
    logic [31:0]           word_q, word_d;

    pipe_pattern_gen #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_gen (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .advance  (pipe_in_write),
        .expected (expected)
    );

    assign mismatch = pipe_in_write && (pipe_in_data != expected);

    always_comb begin
        throttle_d = throttle_set ? throttle_val
                                  : {throttle_q[THROTTLE_W-2:0], throttle_q[THROTTLE_W-1]};
        word_d = pipe_in_write ? word_q + 32'd1 : word_q;
        // Saturate: stop at all-ones instead of wrapping to zero.
        err_d  = (mismatch && (err_q != '1)) ? err_q + ERR_W'(1) : err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            throttle_q <= '1;
            ready_q    <= 1'b0;
            err_q      <= '0;
            word_q     <= '0;
        end else begin
            throttle_q <= throttle_d;
            ready_q    <= throttle_q[THROTTLE_W-1];
            err_q      <= err_d;
            word_q     <= word_d;
        end
    end

    assign pipe_in_ready = ready_q;
    assign error_count   = err_q;
    assign word_count    = word_q;

`ifdef PIPE_IN_CHECKER_ERR_CAPTURE_EN
    logic              cap_valid_q;
    logic [31:0]       cap_index_q;
    logic [DATA_W-1:0] cap_exp_q;
    logic [DATA_W-1:0] cap_rcv_q;

    // Only the first mismatch after reset is recorded; the valid flag locks it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_valid_q <= 1'b0;
            cap_index_q <= '0;
            cap_exp_q   <= '0;
            cap_rcv_q   <= '0;
        end else if (mismatch && !cap_valid_q) begin
            cap_valid_q <= 1'b1;
            cap_index_q <= word_q;
            cap_exp_q   <= expected;
            cap_rcv_q   <= pipe_in_data;
        end
    end

    assign first_err_valid    = cap_valid_q;
    assign first_err_index    = cap_index_q;
    assign first_err_expected = cap_exp_q;
    assign first_err_received = cap_rcv_q;
`else
    assign first_err_valid    = 1'b0;
    assign first_err_index    = '0;
    assign first_err_expected = '0;
    assign first_err_received = '0;
`endif

endmodule

// File: tb/tb_pipe_in_checker.sv
// tb_pipe_in_checker
// Directed bench for pipe_in_checker using three instances:
//   a: DATA_W=16, ERR_W=4   (LFSR, mid-stream reset, saturation)
//   b: DATA_W=32            (counter with one bad word, throttle)
//   c: DATA_W=64            (walking-ones wrap, mode 11)
// First-error fields are checked against the capture record when
// PIPE_IN_CHECKER_ERR_CAPTURE_EN is defined and against zero otherwise.
module tb_pipe_in_checker;

    logic clk;

    // instance a
    logic        rst_a, ts_a, wr_a, rdy_a, fv_a;
    logic [1:0]  mode_a;
    logic [31:0] tv_a, wc_a, fi_a;
    logic [15:0] d_a, fe_a, fr_a;
    logic [3:0]  ec_a;

    // instance b
    logic        rst_b, ts_b, wr_b, rdy_b, fv_b;
    logic [1:0]  mode_b;
    logic [31:0] tv_b, wc_b, fi_b;
    logic [31:0] d_b, fe_b, fr_b;
    logic [15:0] ec_b;

    // instance c
    logic        rst_c, ts_c, wr_c, rdy_c, fv_c;
    logic [1:0]  mode_c;
    logic [31:0] tv_c, wc_c, fi_c;
    logic [63:0] d_c, fe_c, fr_c;
    logic [15:0] ec_c;

    int n_vec = 0;
    int n_mis = 0;

    // expected ready sequence for the throttle scoreboard
    logic [0:0] exp_q[$];

    pipe_in_checker #(.DATA_W(16), .ERR_W(4)) u_a (
        .clk(clk), .reset(rst_a), .mode(mode_a), .throttle_set(ts_a), .throttle_val(tv_a),
        .pipe_in_write(wr_a), .pipe_in_data(d_a), .pipe_in_ready(rdy_a),
        .error_count(ec_a), .word_count(wc_a), .first_err_valid(fv_a),
        .first_err_index(fi_a), .first_err_expected(fe_a), .first_err_received(fr_a)
    );

    pipe_in_checker #(.DATA_W(32)) u_b (
        .clk(clk), .reset(rst_b), .mode(mode_b), .throttle_set(ts_b), .throttle_val(tv_b),
        .pipe_in_write(wr_b), .pipe_in_data(d_b), .pipe_in_ready(rdy_b),
        .error_count(ec_b), .word_count(wc_b), .first_err_valid(fv_b),
        .first_err_index(fi_b), .first_err_expected(fe_b), .first_err_received(fr_b)
    );

    pipe_in_checker #(.DATA_W(64)) u_c (
        .clk(clk), .reset(rst_c), .mode(mode_c), .throttle_set(ts_c), .throttle_val(tv_c),
        .pipe_in_write(wr_c), .pipe_in_data(d_c), .pipe_in_ready(rdy_c),
        .error_count(ec_c), .word_count(wc_c), .first_err_valid(fv_c),
        .first_err_index(fi_c), .first_err_expected(fe_c), .first_err_received(fr_c)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic wr_a_word(input logic [15:0] d);
        wr_a = 1'b1; d_a = d;
        @(posedge clk); #1;
        wr_a = 1'b0;
    endtask

    task automatic wr_b_word(input logic [31:0] d);
        wr_b = 1'b1; d_b = d;
        @(posedge clk); #1;
        wr_b = 1'b0;
    endtask

    task automatic wr_c_word(input logic [63:0] d);
        wr_c = 1'b1; d_c = d;
        @(posedge clk); #1;
        wr_c = 1'b0;
    endtask

    task automatic chk_cap_a(input string tag, input logic [31:0] idx,
                             input logic [15:0] e, input logic [15:0] r);
`ifdef PIPE_IN_CHECKER_ERR_CAPTURE_EN
        chk({tag, "_valid"}, 64'(fv_a), 64'd1);
        chk({tag, "_index"}, 64'(fi_a), 64'(idx));
        chk({tag, "_exp"},   64'(fe_a), 64'(e));
        chk({tag, "_rcv"},   64'(fr_a), 64'(r));
`else
        chk({tag, "_valid"}, 64'(fv_a), 64'd0);
        chk({tag, "_index"}, 64'(fi_a), 64'd0);
        chk({tag, "_exp"},   64'(fe_a), 64'd0);
        chk({tag, "_rcv"},   64'(fr_a), 64'd0);
`endif
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] lfsr_tbl [5];
    logic [31:0] cnt_tbl  [4];
    logic [31:0] mask;

    initial begin
        lfsr_tbl[0] = 16'h0001; lfsr_tbl[1] = 16'h0003; lfsr_tbl[2] = 16'h0006;
        lfsr_tbl[3] = 16'h000D; lfsr_tbl[4] = 16'h0BAD;  // last one is wrong (want 0x001B)
        cnt_tbl[0] = 32'h0; cnt_tbl[1] = 32'h1; cnt_tbl[2] = 32'hDEAD; cnt_tbl[3] = 32'h3;

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        mode_a = 2'b01; mode_b = 2'b00; mode_c = 2'b10;
        ts_a = 1'b0; ts_b = 1'b0; ts_c = 1'b0;
        tv_a = '0; tv_b = '0; tv_c = '0;
        wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0;
        d_a = '0; d_b = '0; d_c = '0;

        // reset values
        #3;
        chk("rst_ready",  64'(rdy_b), 64'd0);
        chk("rst_errcnt", 64'(ec_b),  64'd0);
        chk("rst_wordcnt",64'(wc_b),  64'd0);
        chk("rst_fvalid", 64'(fv_b),  64'd0);
        chk("rst_findex", 64'(fi_b),  64'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst_a", 64'(rdy_a), 64'd1);
        chk("ready_after_rst_b", 64'(rdy_b), 64'd1);

        // ---- a: LFSR, DATA_W=16 ----
        for (int i = 0; i < 3; i++) wr_a_word(lfsr_tbl[i]);
        chk("lfsr_errcnt", 64'(ec_a), 64'd0);
        chk("lfsr_wordcnt", 64'(wc_a), 64'd3);
        for (int i = 3; i < 5; i++) wr_a_word(lfsr_tbl[i]);
        chk("lfsr_bad_errcnt", 64'(ec_a), 64'd1);
        chk("lfsr_bad_wordcnt", 64'(wc_a), 64'd5);
        chk_cap_a("lfsr_cap", 32'd4, 16'h001B, 16'h0BAD);

        // asynchronous reset mid-cycle, checked before the next edge
        rst_a = 1'b1;
        #2;
        chk("async_rst_errcnt", 64'(ec_a), 64'd0);
        chk("async_rst_wordcnt", 64'(wc_a), 64'd0);
        chk("async_rst_fvalid", 64'(fv_a), 64'd0);
        rst_a = 1'b0;
        @(posedge clk); #1;
        wr_a_word(16'h0001);
        chk("post_rst_errcnt", 64'(ec_a), 64'd0);
        chk("post_rst_wordcnt", 64'(wc_a), 64'd1);

        // ---- a: saturation, ERR_W=4, counter mode ----
        rst_a = 1'b1; mode_a = 2'b00;
        #2; rst_a = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) wr_a_word(16'hFFFF);
        chk("sat_errcnt_15", 64'(ec_a), 64'hF);
        for (int i = 0; i < 5; i++) wr_a_word(16'hFFFF);
        chk("sat_errcnt_20", 64'(ec_a), 64'hF);
        chk("sat_wordcnt", 64'(wc_a), 64'd20);
        chk_cap_a("sat_cap", 32'd0, 16'h0000, 16'hFFFF);

        // ---- b: counter, DATA_W=32, one bad word ----
        for (int i = 0; i < 3; i++) wr_b_word(cnt_tbl[i]);
        chk("cnt_errcnt_at_bad", 64'(ec_b), 64'd1);
`ifdef PIPE_IN_CHECKER_ERR_CAPTURE_EN
        chk("cnt_fvalid", 64'(fv_b), 64'd1);
        chk("cnt_findex", 64'(fi_b), 64'd2);
        chk("cnt_fexp",   64'(fe_b), 64'h2);
        chk("cnt_frcv",   64'(fr_b), 64'hDEAD);
`else
        chk("cnt_fvalid", 64'(fv_b), 64'd0);
        chk("cnt_frcv",   64'(fr_b), 64'd0);
`endif
        wr_b_word(cnt_tbl[3]);
        chk("cnt_errcnt", 64'(ec_b), 64'd1);
        chk("cnt_wordcnt", 64'(wc_b), 64'd4);

        // ---- b: throttle 0xAAAAAAAA, ready sequence from a mask model ----
        ts_b = 1'b1; tv_b = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        ts_b = 1'b0;
        mask = 32'hAAAA_AAAA;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(mask[31]);
            mask = {mask[30:0], mask[31]};
        end
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk($sformatf("thr_alt_%0d", k), 64'(rdy_b), 64'(exp_q.pop_front()));
        end

        // ---- b: mask 0; load edge still shows the old MSB, then ready stays 0 ----
        ts_b = 1'b1; tv_b = 32'h0;
        exp_q.push_back(mask[31]);
        @(posedge clk); #1;
        ts_b = 1'b0;
        chk("thr_zero_load", 64'(rdy_b), 64'(exp_q.pop_front()));
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(1'b0);
            wr_b_word(32'(k + 4));  // counter continues at 4
            chk($sformatf("thr_zero_%0d", k), 64'(rdy_b), 64'(exp_q.pop_front()));
        end
        chk("thr_zero_wordcnt", 64'(wc_b), 64'd8);
        chk("thr_zero_errcnt", 64'(ec_b), 64'd1);

        // ---- c: walking-ones DATA_W=64, wrap after 64 words ----
        for (int i = 0; i < 64; i++) wr_c_word(64'd1 << i);
        wr_c_word(64'd1);
        chk("walk_errcnt", 64'(ec_c), 64'd0);
        chk("walk_wordcnt", 64'(wc_c), 64'd65);
        wr_c_word(64'd1);  // generator is now at bit 1
        chk("walk_next_errcnt", 64'(ec_c), 64'd1);

        // ---- c: mode 11 behaves as counter ----
        rst_c = 1'b1; mode_c = 2'b11;
        #2; rst_c = 1'b0;
        @(posedge clk); #1;
        wr_c_word(64'd0);
        wr_c_word(64'd1);
        chk("mode3_errcnt", 64'(ec_c), 64'd0);
        wr_c_word(64'd5);
        chk("mode3_bad_errcnt", 64'(ec_c), 64'd1);
        chk("mode3_wordcnt", 64'(wc_c), 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
